// File: rtl/data_memory_unit_if.sv
// Initiator/responder bundle for the CPU data-memory port.
// The master side issues load/store requests; the slave side returns load data, stall and fault.
interface data_memory_unit_if;
   logic [1:0]  MEM_write_length;
   logic [1:0]  MEM_read_length;
   logic        MEM_read_signed;
   logic [31:0] MEM_write_data;
   logic [31:0] MEM_write_address;
   logic [31:0] MEM_read_address;
   logic [31:0] MEM_read_data;
   logic        MEM_busy;
   logic        MEM_fault;

   modport master (
      output MEM_write_length, MEM_read_length, MEM_read_signed,
             MEM_write_data, MEM_write_address, MEM_read_address,
      input  MEM_read_data, MEM_busy, MEM_fault
   );

   modport slave (
      input  MEM_write_length, MEM_read_length, MEM_read_signed,
             MEM_write_data, MEM_write_address, MEM_read_address,
      output MEM_read_data, MEM_busy, MEM_fault
   );
endinterface

// File: rtl/data_memory_unit.sv
// Word-organised little-endian data memory; in-word accesses complete in the same cycle.
// Word-crossing accesses split over two cycles, MEM_busy stalling the initiator during the first.
module data_memory_unit #(
   parameter int    DEPTH_WORDS      = 1024,
   parameter bit    ALLOW_MISALIGNED = 1'b1,
   parameter string INIT_FILE        = ""
) (
   input logic               SYS_clk,
   input logic               SYS_reset,
   data_memory_unit_if.slave mem_if
);
   localparam int          AW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [31:0] DEPTH32 = 32'(DEPTH_WORDS);

   typedef enum logic [1:0] {IDLE, RD2, WR2} state_t;

   state_t          state_q, state_d;
   logic [AW-1:0]   idx2_q, idx2_d;
   logic [31:0]     hold_q, hold_d;
   logic [3:0]      hmask_q, hmask_d;
   logic [1:0]      off_q, off_d;
   logic [2:0]      n_q, n_d;
   logic            sgn_q, sgn_d;

   logic [31:0]     mem [DEPTH_WORDS];

   logic            we;
   logic [AW-1:0]   we_idx;
   logic [3:0]      we_mask;
   logic [31:0]     we_dat;

   function automatic logic [2:0] len_to_n(input logic [1:0] len);
      case (len)
         2'b01:   return 3'd1;
         2'b10:   return 3'd2;
         2'b11:   return 3'd4;
         default: return 3'd0;
      endcase
   endfunction

   function automatic logic [31:0] extend(input logic [31:0] raw, input logic [2:0] n, input logic sgn);
      case (n)
         3'd1:    return sgn ? {{24{raw[7]}}, raw[7:0]} : {24'b0, raw[7:0]};
         3'd2:    return sgn ? {{16{raw[15]}}, raw[15:0]} : {16'b0, raw[15:0]};
         3'd4:    return raw;
         default: return 32'b0;
      endcase
   endfunction

   logic [29:0] w_idx, r_idx;
   logic [1:0]  w_off, r_off;
   logic [2:0]  w_n, r_n;
   logic [7:0]  w_m8;
   logic        w_act, r_act, w_cross, r_cross, w_bad, r_bad;
   logic [63:0] w_wide;
   logic [31:0] rd_word;

   assign w_idx   = mem_if.MEM_write_address[31:2];
   assign w_off   = mem_if.MEM_write_address[1:0];
   assign w_n     = len_to_n(mem_if.MEM_write_length);
   assign w_act   = (mem_if.MEM_write_length != 2'b00);
   assign r_idx   = mem_if.MEM_read_address[31:2];
   assign r_off   = mem_if.MEM_read_address[1:0];
   assign r_n     = len_to_n(mem_if.MEM_read_length);
   assign r_act   = (mem_if.MEM_read_length != 2'b00);

   // Bits [3:0] are lanes of word[index], bits [7:4] spill into word[index+1].
   assign w_m8    = ((8'd1 << w_n) - 8'd1) << w_off;
   assign w_cross = |w_m8[7:4];
   assign r_cross = ({2'b0, r_off} + {1'b0, r_n}) > 4'd4;
   assign w_wide  = {32'b0, mem_if.MEM_write_data} << {w_off, 3'b000};

   assign w_bad = w_act && (({2'b0, w_idx} >= DEPTH32) ||
                            (w_cross && ({2'b0, w_idx} + 32'd1 >= DEPTH32)) ||
                            (w_cross && !ALLOW_MISALIGNED));
   assign r_bad = r_act && (({2'b0, r_idx} >= DEPTH32) ||
                            (r_cross && ({2'b0, r_idx} + 32'd1 >= DEPTH32)) ||
                            (r_cross && !ALLOW_MISALIGNED));

   assign rd_word = mem[r_idx[AW-1:0]];

   always_comb begin
      state_d              = state_q;
      idx2_d               = idx2_q;
      hold_d               = hold_q;
      hmask_d              = hmask_q;
      off_d                = off_q;
      n_d                  = n_q;
      sgn_d                = sgn_q;
      we                   = 1'b0;
      we_idx               = w_idx[AW-1:0];
      we_mask              = 4'b0;
      we_dat               = w_wide[31:0];
      mem_if.MEM_busy      = 1'b0;
      mem_if.MEM_fault     = 1'b0;
      mem_if.MEM_read_data = 32'b0;

      case (state_q)
         IDLE: begin
            mem_if.MEM_fault = w_bad || r_bad;
            if (w_act && !w_bad) begin
               we      = 1'b1;
               we_mask = w_m8[3:0];
               if (w_cross) begin
                  mem_if.MEM_busy = 1'b1;
                  state_d         = WR2;
                  idx2_d          = AW'(w_idx + 30'd1);
                  hold_d          = w_wide[63:32];
                  hmask_d         = w_m8[7:4];
               end
            end
            if (r_act && !r_bad) begin
               if (!r_cross) begin
                  mem_if.MEM_read_data = extend(rd_word >> {r_off, 3'b000}, r_n, mem_if.MEM_read_signed);
               end else if (!w_act) begin
                  mem_if.MEM_busy = 1'b1;
                  state_d         = RD2;
                  idx2_d          = AW'(r_idx + 30'd1);
                  hold_d          = rd_word >> {r_off, 3'b000};
                  off_d           = r_off;
                  n_d             = r_n;
                  sgn_d           = mem_if.MEM_read_signed;
               end
            end
         end
         WR2: begin
            we      = 1'b1;
            we_idx  = idx2_q;
            we_mask = hmask_q;
            we_dat  = hold_q;
            state_d = IDLE;
            if (r_act && !r_bad && !r_cross) begin
               mem_if.MEM_read_data = extend(rd_word >> {r_off, 3'b000}, r_n, mem_if.MEM_read_signed);
            end
         end
         RD2: begin
            // Upper bytes come from the next word, placed just above the held low bytes.
            mem_if.MEM_read_data = extend(hold_q | (mem[idx2_q] << {3'd4 - {1'b0, off_q}, 3'b000}), n_q, sgn_q);
            state_d              = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (SYS_reset) begin
         we                   = 1'b0;
         mem_if.MEM_busy      = 1'b0;
         mem_if.MEM_fault     = 1'b0;
         mem_if.MEM_read_data = 32'b0;
      end
   end

   always_ff @(posedge SYS_clk or posedge SYS_reset) begin
      if (SYS_reset) begin
         state_q <= IDLE;
         idx2_q  <= '0;
         hold_q  <= '0;
         hmask_q <= '0;
         off_q   <= '0;
         n_q     <= '0;
         sgn_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx2_q  <= idx2_d;
         hold_q  <= hold_d;
         hmask_q <= hmask_d;
         off_q   <= off_d;
         n_q     <= n_d;
         sgn_q   <= sgn_d;
      end
   end

   initial begin
      for (int i = 0; i < DEPTH_WORDS; i++) mem[i] = 32'b0;
   end

   // Storage has no reset; contents survive SYS_reset.
   always @(posedge SYS_clk) begin
      if (we) begin
         for (int b = 0; b < 4; b++) begin
            if (we_mask[b]) mem[we_idx][8*b +: 8] <= we_dat[8*b +: 8];
         end
      end
   end
endmodule
